// File: rtl/des_dec_keysched_pkg.sv
// Shared DES key-schedule constants, state type and bit-permutation helpers.
// Bit vectors keep FIPS-46 bit 1 at the MSB, so FIPS bit p of an N-bit vector sits at index N-p.
package des_dec_keysched_pkg;

    localparam int unsigned KEY_W  = 64;
    localparam int unsigned CD_W   = 56;
    localparam int unsigned HALF_W = 28;
    localparam int unsigned SK_W   = 48;
    localparam int unsigned RND_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Left-rotation amount applied to produce C(i+1)/D(i+1), indexed 0..15
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CD_W; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SK_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SK_W; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_TAB[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] amt);
        case (amt)
            2'd0:    return x;
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return {x[24:0], x[27:25]};
        endcase
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] amt);
        case (amt)
            2'd0:    return x;
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return {x[2:0], x[27:3]};
        endcase
    endfunction

    // DES keys carry odd parity in every byte
    function automatic logic odd_parity_ok(input logic [KEY_W-1:0] k);
        logic ok;
        ok = 1'b1;
        for (int unsigned b = 0; b < 8; b++) begin
            if (!(^k[6'(8 * b) +: 8])) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// C/D key-register: loads the initial C||D value and steps both 28-bit halves
// by a left or right rotation of 0..3 positions.
module des_cd_rotator
    import des_dec_keysched_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [CD_W-1:0] load_val_i,
    input  logic            step_i,
    input  logic            dir_i,
    input  logic [1:0]      amt_i,
    output logic [CD_W-1:0] cd_o
);

    logic [CD_W-1:0]   cd_q;
    logic [CD_W-1:0]   cd_d;
    logic [HALF_W-1:0] c_rot;
    logic [HALF_W-1:0] d_rot;

    // dir_i = 1 rotates right (decrypt), 0 rotates left (encrypt)
    always_comb begin
        c_rot = dir_i ? rotr28(cd_q[55:28], amt_i) : rotl28(cd_q[55:28], amt_i);
        d_rot = dir_i ? rotr28(cd_q[27:0],  amt_i) : rotl28(cd_q[27:0],  amt_i);
        cd_d  = cd_q;
        if (load_i) begin
            cd_d = load_val_i;
        end else if (step_i) begin
            cd_d = {c_rot, d_rot};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cd_q <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end

    assign cd_o = cd_q;

endmodule

// File: rtl/des_dec_keysched.sv
// Sequential DES subkey streamer: one key in, 16 round subkeys out one per beat,
// forward (K1..K16) or reverse (K16..K1) order selected by the mode latched with the key.
module des_dec_keysched
    import des_dec_keysched_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              mode,
    output logic              sk_valid,
    input  logic              sk_ready,
    output logic [SK_W-1:0]   sk_out,
    output logic [RND_W-1:0]  sk_num,
    output logic              sk_last,
    output logic              key_err
);

    state_t             state_q, state_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic               mode_q, mode_d;
    logic               key_ready_q, key_ready_d;
    logic               sk_valid_q, sk_valid_d;
    logic               key_err_q, key_err_d;

    logic               key_acc;
    logic               sk_acc;
    logic               parity_bad;
    logic               cd_load;
    logic               cd_step;
    logic [1:0]         rot_amt;
    logic [CD_W-1:0]    pc1_v;
    logic [CD_W-1:0]    cd_load_val;
    logic [CD_W-1:0]    cd;

    assign key_acc    = key_valid && key_ready_q;
    assign sk_acc     = sk_valid_q && sk_ready;
    assign parity_bad = PARITY_CHECK && !odd_parity_ok(key_in);
    assign cd_load    = key_acc && !parity_bad;
    assign cd_step    = sk_acc && (rnd_q != 4'd15);

    // Encrypt starts from C1/D1; decrypt starts from C0/D0, which equals C16/D16
    assign pc1_v       = pc1(key_in);
    assign cd_load_val = mode ? pc1_v
                              : {rotl28(pc1_v[55:28], 2'd1), rotl28(pc1_v[27:0], 2'd1)};
    assign rot_amt     = mode_q ? SHIFT[4'd15 - rnd_q] : SHIFT[rnd_q + 4'd1];

    des_cd_rotator u_cd_rotator (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cd_load),
        .load_val_i (cd_load_val),
        .step_i     (cd_step),
        .dir_i      (mode_q),
        .amt_i      (rot_amt),
        .cd_o       (cd)
    );

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        mode_d    = mode_q;
        key_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_acc) begin
                    if (parity_bad) begin
                        key_err_d = 1'b1;
                    end else begin
                        mode_d  = mode;
                        rnd_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (sk_acc) begin
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == 4'd15) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        key_ready_d = (state_d == ST_IDLE);
        sk_valid_d  = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            mode_q      <= 1'b0;
            key_ready_q <= 1'b0;
            sk_valid_q  <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            mode_q      <= mode_d;
            key_ready_q <= key_ready_d;
            sk_valid_q  <= sk_valid_d;
            key_err_q   <= key_err_d;
        end
    end

    assign key_ready = key_ready_q;
    assign sk_valid  = sk_valid_q;
    assign key_err   = key_err_q;
    assign sk_out    = pc2(cd);
    assign sk_num    = mode_q ? (4'd15 - rnd_q) : rnd_q;
    assign sk_last   = (rnd_q == 4'd15);

endmodule

// File: tb/tb_des_dec_keysched.sv
// Directed bench for the DES subkey streamer: a parity-ignoring instance (a_*) and a
// parity-checking instance (b_*) driven from one linear stimulus sequence.
module tb_des_dec_keysched;

    logic        clk;
    logic        rst_n;

    logic        a_key_valid, a_key_ready, a_mode, a_sk_valid, a_sk_ready, a_sk_last, a_key_err;
    logic [63:0] a_key_in;
    logic [47:0] a_sk_out;
    logic [3:0]  a_sk_num;

    logic        b_key_valid, b_key_ready, b_mode, b_sk_valid, b_sk_ready, b_sk_last, b_key_err;
    logic [63:0] b_key_in;
    logic [47:0] b_sk_out;
    logic [3:0]  b_sk_num;

    int n_tests = 0;
    int n_fail  = 0;

    // K1..K16 for key 133457799BBCDFF1
    logic [47:0] ktab [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BADP = 64'h133457799BBCDFF0;
    localparam logic [63:0] KEY_WEAK = 64'h0101010101010101;

    des_dec_keysched #(.PARITY_CHECK(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .key_valid(a_key_valid), .key_ready(a_key_ready), .key_in(a_key_in), .mode(a_mode),
        .sk_valid(a_sk_valid), .sk_ready(a_sk_ready), .sk_out(a_sk_out), .sk_num(a_sk_num),
        .sk_last(a_sk_last), .key_err(a_key_err)
    );

    des_dec_keysched #(.PARITY_CHECK(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .key_valid(b_key_valid), .key_ready(b_key_ready), .key_in(b_key_in), .mode(b_mode),
        .sk_valid(b_sk_valid), .sk_ready(b_sk_ready), .sk_out(b_sk_out), .sk_num(b_sk_num),
        .sk_last(b_sk_last), .key_err(b_key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept_a(input logic [63:0] key, input logic m);
        a_key_in    = key;
        a_mode      = m;
        a_key_valid = 1'b1;
        tick();
        a_key_valid = 1'b0;
    endtask

    // Play beats 0..nbeats-1 on instance A, with optional random stalls before each beat
    task automatic stream_a(input logic dec, input int stall_pct, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            int kidx;
            kidx = dec ? 15 - b : b;
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(99) < stall_pct) begin
                    a_sk_ready = 1'b0;
                    tick();
                    chk("stall_sk_out",    64'(a_sk_out),    64'(ktab[kidx]));
                    chk("stall_sk_num",    64'(a_sk_num),    64'(kidx));
                    chk("stall_sk_valid",  64'(a_sk_valid),  64'd1);
                    chk("stall_key_ready", 64'(a_key_ready), 64'd0);
                end
            end
            chk("sk_out",    64'(a_sk_out),    64'(ktab[kidx]));
            chk("sk_num",    64'(a_sk_num),    64'(kidx));
            chk("sk_last",   64'(a_sk_last),   64'(b == 15));
            chk("sk_valid",  64'(a_sk_valid),  64'd1);
            chk("key_ready", 64'(a_key_ready), 64'd0);
            a_sk_ready = 1'b1;
            tick();
        end
        a_sk_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_key_valid = 1'b0; a_key_in = '0; a_mode = 1'b0; a_sk_ready = 1'b0;
        b_key_valid = 1'b0; b_key_in = '0; b_mode = 1'b0; b_sk_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_key_ready", 64'(a_key_ready), 64'd0);
        chk("rst_sk_valid",  64'(a_sk_valid),  64'd0);
        chk("rst_key_err",   64'(a_key_err),   64'd0);
        chk("rst_sk_out",    64'(a_sk_out),    64'd0);
        chk("rst_sk_num",    64'(a_sk_num),    64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_key_ready", 64'(a_key_ready), 64'd1);
        chk("idle_sk_valid",  64'(a_sk_valid),  64'd0);

        // Decrypt order, no stalls
        accept_a(KEY_GOOD, 1'b1);
        stream_a(1'b1, 0, 16);
        chk("dec_end_key_ready", 64'(a_key_ready), 64'd1);
        chk("dec_end_sk_valid",  64'(a_sk_valid),  64'd0);

        // Encrypt order
        accept_a(KEY_GOOD, 1'b0);
        stream_a(1'b0, 0, 16);
        chk("enc_end_sk_valid", 64'(a_sk_valid), 64'd0);

        // Decrypt with random backpressure
        accept_a(KEY_GOOD, 1'b1);
        stream_a(1'b1, 30, 16);
        chk("stall_end_sk_valid", 64'(a_sk_valid), 64'd0);

        // Reset in the middle of a key, then a clean restart
        accept_a(KEY_GOOD, 1'b1);
        stream_a(1'b1, 0, 7);
        chk("pre_rst_sk_out", 64'(a_sk_out), 64'(ktab[8]));
        rst_n = 1'b0;
        tick();
        chk("mid_rst_sk_valid",  64'(a_sk_valid),  64'd0);
        chk("mid_rst_key_ready", 64'(a_key_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_key_ready", 64'(a_key_ready), 64'd1);
        tick();
        chk("post_rst_sk_valid", 64'(a_sk_valid), 64'd0);
        accept_a(KEY_GOOD, 1'b1);
        stream_a(1'b1, 0, 16);

        // Parity bit ignored on the non-checking instance
        accept_a(KEY_BADP, 1'b1);
        chk("a_nochk_key_err", 64'(a_key_err), 64'd0);
        stream_a(1'b1, 0, 16);

        // Parity rejection on the checking instance
        b_key_in = KEY_BADP; b_mode = 1'b1; b_key_valid = 1'b1;
        tick();
        b_key_valid = 1'b0;
        chk("b_key_err_pulse", 64'(b_key_err),   64'd1);
        chk("b_rej_sk_valid",  64'(b_sk_valid),  64'd0);
        chk("b_rej_key_ready", 64'(b_key_ready), 64'd1);
        tick();
        chk("b_key_err_clear", 64'(b_key_err),  64'd0);
        chk("b_rej_sk_valid2", 64'(b_sk_valid), 64'd0);

        // Weak key with valid parity: accepted, all-zero subkeys
        b_key_in = KEY_WEAK; b_mode = 1'b1; b_key_valid = 1'b1;
        tick();
        b_key_valid = 1'b0;
        chk("b_weak_key_err", 64'(b_key_err), 64'd0);
        for (int b = 0; b < 16; b++) begin
            chk("b_weak_sk_valid", 64'(b_sk_valid), 64'd1);
            chk("b_weak_sk_out",   64'(b_sk_out),   64'd0);
            chk("b_weak_sk_num",   64'(b_sk_num),   64'(15 - b));
            b_sk_ready = 1'b1;
            tick();
        end
        b_sk_ready = 1'b0;
        chk("b_weak_end_sk_valid", 64'(b_sk_valid), 64'd0);

        // Back-to-back keys with key_valid held; mode change mid-run must not matter
        a_key_in = KEY_GOOD; a_mode = 1'b1; a_key_valid = 1'b1;
        tick();
        a_mode = 1'b0;
        stream_a(1'b1, 0, 16);
        chk("b2b_gap_key_ready", 64'(a_key_ready), 64'd1);
        chk("b2b_gap_sk_valid",  64'(a_sk_valid),  64'd0);
        tick();
        a_key_valid = 1'b0;
        chk("b2b_second_sk_valid", 64'(a_sk_valid), 64'd1);
        chk("b2b_second_sk_out",   64'(a_sk_out),   64'(ktab[0]));
        chk("b2b_second_sk_num",   64'(a_sk_num),   64'd0);
        stream_a(1'b0, 0, 16);
        chk("b2b_end_sk_valid", 64'(a_sk_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
